// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset/power-up sequencer for the FPGA SoC top.
// Synchronizes and debounces the board reset button and wake pin, waits for a
// stable MMCM lock, then releases peripheral reset and the SoC AON external
// reset in a fixed counted order. Lock loss or a button press re-runs it.
// Optional MMCM lock watchdog: define RST_SEQ_LOCK_WDOG_EN.
module rst_seq_ctrl #(
  parameter int unsigned DBNC_CYCLES     = 16,
  parameter int unsigned LOCK_HOLD       = 64,
  parameter int unsigned SOC_DELAY       = 16,
  parameter int unsigned LOCK_TIMEOUT    = 4096,
  parameter int unsigned MMCM_RST_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ext_rst_n_i,
  input  logic       wakeup_n_i,
  input  logic       mmcm_locked_i,
  output logic       periph_rst_o,
  output logic       soc_erst_n_o,
  output logic       dwakeup_n_o,
  output logic       mmcm_rst_o,
  output logic [2:0] seq_state_o,
  output logic [7:0] rst_cnt_o
);

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_PERIPH_UP  = 3'd3,
    ST_RUN        = 3'd4,
    ST_LOCK_RETRY = 3'd5
  } state_e;

  // Shared sequence counter must hold the largest terminal count in use.
  localparam int unsigned MAX_AB  = (LOCK_HOLD > SOC_DELAY) ? LOCK_HOLD : SOC_DELAY;
  localparam int unsigned MAX_CD  = (LOCK_TIMEOUT > MMCM_RST_CYCLES) ? LOCK_TIMEOUT : MMCM_RST_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned DBNC_W  = $clog2(DBNC_CYCLES);

  localparam logic [DBNC_W-1:0] DBNC_LAST = DBNC_W'(DBNC_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(LOCK_HOLD - 1);
  localparam logic [CNT_W-1:0]  SOC_LAST  = CNT_W'(SOC_DELAY - 1);
`ifdef RST_SEQ_LOCK_WDOG_EN
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  RETRY_LAST   = CNT_W'(MMCM_RST_CYCLES - 1);
`endif

  // Synchronizer bit order: {ext, wake, lock}; reset value ext=0, wake=1, lock=0.
  localparam logic [2:0] SYNC_RST = 3'b010;

  logic [2:0]        sync1_q, sync1_d, sync2_q, sync2_d;
  logic              ext_f_q, ext_f_d, wake_f_q, wake_f_d;
  logic [DBNC_W-1:0] ext_dc_q, ext_dc_d, wake_dc_q, wake_dc_d;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        rst_cnt_q, rst_cnt_d;

  logic ext_s, wake_s, lock_s;
  assign ext_s  = sync2_q[2];
  assign wake_s = sync2_q[1];
  assign lock_s = sync2_q[0];

  // Two-flop synchronizer shift and debounce filters for ext and wake.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    sync1_d   = {ext_rst_n_i, wakeup_n_i, mmcm_locked_i};
    sync2_d   = sync1_q;
    ext_f_d   = ext_f_q;
    ext_dc_d  = '0;
    wake_f_d  = wake_f_q;
    wake_dc_d = '0;
    if (ext_s != ext_f_q) begin
      if (ext_dc_q == DBNC_LAST) ext_f_d  = ext_s;
      else                       ext_dc_d = ext_dc_q + 1'b1;
    end
    if (wake_s != wake_f_q) begin
      if (wake_dc_q == DBNC_LAST) wake_f_d  = wake_s;
      else                        wake_dc_d = wake_dc_q + 1'b1;
    end
  end

  // Input conditioning registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      sync1_q   <= SYNC_RST;
      sync2_q   <= SYNC_RST;
      ext_f_q   <= 1'b0;
      ext_dc_q  <= '0;
      wake_f_q  <= 1'b1;
      wake_dc_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      ext_f_q   <= ext_f_d;
      ext_dc_q  <= ext_dc_d;
      wake_f_q  <= wake_f_d;
      wake_dc_q <= wake_dc_d;
    end
  end

  // Next-state, shared counter and RUN-exit counter.
  always_comb begin
    state_d = state_q;
    if (!ext_f_q) begin
      state_d = ST_RESET;
    end else begin
      case (state_q)
        ST_RESET:     state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (lock_s) state_d = ST_HOLD;
`ifdef RST_SEQ_LOCK_WDOG_EN
          else if (cnt_q == TIMEOUT_LAST) state_d = ST_LOCK_RETRY;
`endif
        end
        ST_HOLD: begin
          if (!lock_s)                 state_d = ST_WAIT_LOCK;
          else if (cnt_q == HOLD_LAST) state_d = ST_PERIPH_UP;
        end
        ST_PERIPH_UP: begin
          if (!lock_s)                state_d = ST_WAIT_LOCK;
          else if (cnt_q == SOC_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!lock_s) state_d = ST_WAIT_LOCK;
        end
        ST_LOCK_RETRY: begin
`ifdef RST_SEQ_LOCK_WDOG_EN
          if (cnt_q == RETRY_LAST) state_d = ST_WAIT_LOCK;
`else
          state_d = ST_WAIT_LOCK;
`endif
        end
        default:      state_d = ST_RESET;
      endcase
    end

    // Counter value is only meaningful in timed states; elsewhere it may wrap freely.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

    rst_cnt_d = rst_cnt_q;
    if (state_q == ST_RUN && state_d != ST_RUN && rst_cnt_q != 8'hFF)
      rst_cnt_d = rst_cnt_q + 8'd1;
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    periph_rst_o = !(state_q == ST_PERIPH_UP || state_q == ST_RUN);
    soc_erst_n_o = (state_q == ST_RUN);
`ifdef RST_SEQ_LOCK_WDOG_EN
    mmcm_rst_o   = (state_q == ST_LOCK_RETRY);
`else
    mmcm_rst_o   = 1'b0;
`endif
    dwakeup_n_o  = wake_f_q;
    seq_state_o  = state_q;
    rst_cnt_o    = rst_cnt_q;
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: self-checking bench for rst_seq_ctrl with a cycle-level
// behavioural reference model and randomized stimulus.
module tb_rst_seq_ctrl;

  localparam int DBNC = 16;
  localparam int LH   = 64;
  localparam int SD   = 16;
  localparam int LT   = 4096;
  localparam int MR   = 8;
`ifdef RST_SEQ_LOCK_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, ext, wake, lock;
  logic       periph_rst_o, soc_erst_n_o, dwakeup_n_o, mmcm_rst_o;
  logic [2:0] seq_state_o;
  logic [7:0] rst_cnt_o;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .DBNC_CYCLES(DBNC), .LOCK_HOLD(LH), .SOC_DELAY(SD),
    .LOCK_TIMEOUT(LT), .MMCM_RST_CYCLES(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ext_rst_n_i(ext), .wakeup_n_i(wake),
    .mmcm_locked_i(lock), .periph_rst_o(periph_rst_o), .soc_erst_n_o(soc_erst_n_o),
    .dwakeup_n_o(dwakeup_n_o), .mmcm_rst_o(mmcm_rst_o), .seq_state_o(seq_state_o),
    .rst_cnt_o(rst_cnt_o)
  );

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: input pipelines, debounced levels and sequencer position.
  bit m_e1, m_e2, m_w1, m_w2, m_l1, m_l2, m_ef, m_wf;
  int m_edc, m_wdc, m_st, m_tin, m_rc;

  function automatic void model_step();
    int nxt;
    if (!rst_n) begin
      m_e1 = 0; m_e2 = 0; m_w1 = 1; m_w2 = 1; m_l1 = 0; m_l2 = 0;
      m_ef = 0; m_wf = 1; m_edc = 0; m_wdc = 0; m_st = 0; m_tin = 0; m_rc = 0;
      return;
    end
    nxt = m_st;
    if (!m_ef) nxt = 0;
    else begin
      case (m_st)
        0: nxt = 1;
        1: if (m_l2) nxt = 2; else if (WDOG && m_tin == LT - 1) nxt = 5;
        2: if (!m_l2) nxt = 1; else if (m_tin == LH - 1) nxt = 3;
        3: if (!m_l2) nxt = 1; else if (m_tin == SD - 1) nxt = 4;
        4: if (!m_l2) nxt = 1;
        5: if (m_tin == MR - 1) nxt = 1;
        default: nxt = 0;
      endcase
    end
    if (m_st == 4 && nxt != 4 && m_rc < 255) m_rc++;
    m_tin = (nxt != m_st) ? 0 : m_tin + 1;
    m_st  = nxt;
    if (m_e2 != m_ef) begin
      if (m_edc == DBNC - 1) begin m_ef = m_e2; m_edc = 0; end
      else m_edc++;
    end else m_edc = 0;
    if (m_w2 != m_wf) begin
      if (m_wdc == DBNC - 1) begin m_wf = m_w2; m_wdc = 0; end
      else m_wdc++;
    end else m_wdc = 0;
    m_e2 = m_e1; m_e1 = ext;
    m_w2 = m_w1; m_w1 = wake;
    m_l2 = m_l1; m_l1 = lock;
  endfunction

  function automatic logic [14:0] m_vec();
    logic [2:0] st;
    logic [7:0] rc;
    st = 3'(m_st);
    rc = 8'(m_rc);
    return {st, (m_st != 3 && m_st != 4), (m_st == 4), m_wf, (WDOG && m_st == 5), rc};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {seq_state_o, periph_rst_o, soc_erst_n_o, dwakeup_n_o, mmcm_rst_o, rst_cnt_o};
  endfunction

  // One clock: advance the model with the inputs the DUT sampled, compare at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check(phase, dut_vec(), m_vec());
  endtask

  task automatic wait_state(input int st, input int budget, input string tag);
    int n = 0;
    while (seq_state_o !== 3'(st) && n < budget) begin
      tick();
      n++;
    end
    check(tag, seq_state_o, st);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n, len, hi_cnt;
    rst_n = 0; ext = 1; wake = 1; lock = 1;

    // Synchronous reset for three edges.
    phase = "reset";
    repeat (3) tick();
    check("rst_state", seq_state_o, 0);
    check("rst_periph", periph_rst_o, 1);
    check("rst_erst", soc_erst_n_o, 0);
    check("rst_dwake", dwakeup_n_o, 1);
    check("rst_cnt", rst_cnt_o, 0);
    check("rst_mmcm", mmcm_rst_o, 0);

    // Power-up sequence with lock held.
    phase = "seq";
    rst_n = 1;
    wait_state(2, 100, "to_hold");
    n = 0;
    while (periph_rst_o === 1'b1 && n < 200) begin tick(); n++; end
    check("hold_len", n, LH);
    n = 0;
    while (soc_erst_n_o === 1'b0 && n < 200) begin tick(); n++; end
    check("periph_up_len", n, SD);
    check("in_run", seq_state_o, 4);

    // Button glitch shorter than the debounce window, then a real press.
    phase = "ext_short";
    ext = 0;
    repeat ($urandom_range(2, 12)) tick();
    ext = 1;
    repeat (30) tick();
    check("glitch_keeps_run", seq_state_o, 4);
    phase = "ext_long";
    ext = 0;
    repeat ($urandom_range(20, 30)) tick();
    check("press_state", seq_state_o, 0);
    check("press_periph", periph_rst_o, 1);
    check("press_erst", soc_erst_n_o, 0);
    check("press_rcnt", rst_cnt_o, 1);
    ext = 1;
    wait_state(4, 300, "reseq_run");

    // Lock loss in RUN and in HOLD.
    phase = "lock_run";
    lock = 0; tick(); lock = 1;
    wait_state(1, 10, "drop_wait");
    check("drop_periph", periph_rst_o, 1);
    check("drop_erst", soc_erst_n_o, 0);
    check("drop_rcnt", rst_cnt_o, 2);
    wait_state(4, 300, "drop_rerun");
    phase = "lock_hold";
    lock = 0; tick(); lock = 1;
    wait_state(2, 20, "to_hold2");
    repeat (28) tick();
    lock = 0; tick(); lock = 1;
    wait_state(1, 10, "hold_drop_wait");
    check("hold_drop_periph", periph_rst_o, 1);
    wait_state(4, 300, "hold_drop_rerun");

    // Drive the RUN-exit counter into saturation.
    phase = "saturate";
    for (int i = 0; i < 300; i++) begin
      lock = 0;
      repeat ($urandom_range(1, 3)) tick();
      lock = 1;
      wait_state(1, 10, "sat_wait");
      wait_state(4, 300, "sat_run");
    end
    check("rcnt_sat", rst_cnt_o, 255);

    // Wake pin debounce.
    phase = "wake";
    wake = 0;
    repeat (5) tick();
    wake = 1;
    repeat (25) tick();
    check("wake_glitch", dwakeup_n_o, 1);
    len = $urandom_range(20, 40);
    wake = 0;
    n = 0;
    while (dwakeup_n_o === 1'b1 && n < 100) begin tick(); n++; end
    check("wake_fall_lat", n, 18);
    repeat (len - n) tick();
    wake = 1;
    n = 0;
    while (dwakeup_n_o === 1'b0 && n < 100) begin tick(); n++; end
    check("wake_rise_lat", n, 18);

    // Lock never returns: watchdog behaviour or indefinite wait.
    phase = "no_lock";
    lock = 0;
    wait_state(1, 10, "nolock_wait");
    n = 0;
    while (seq_state_o === 3'd1 && n < LT + 10) begin tick(); n++; end
    check("wait_timeout", n, WDOG ? LT : LT + 10);
    if (WDOG) begin
      n = 0;
      while (seq_state_o === 3'd5 && n < 50) begin tick(); n++; end
      check("retry_len", n, MR);
      check("retry_back", seq_state_o, 1);
    end
    hi_cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (mmcm_rst_o === 1'b1) hi_cnt++;
    end
    if (!WDOG) begin
      check("no_mmcm_rst", hi_cnt, 0);
      check("still_waiting", seq_state_o, 1);
    end else begin
      check("retries_seen", hi_cnt > 0, 1);
    end
    lock = 1;
    wait_state(4, 300, "relock_run");

    // Random input activity against the model.
    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) ext  = ~ext;
      if ($urandom_range(0, 29) == 0) wake = ~wake;
      if ($urandom_range(0, 24) == 0) lock = ~lock;
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    // Reset in the middle of the sequence.
    phase = "mid_reset";
    rst_n = 1; ext = 1; wake = 1; lock = 0;
    repeat (5) tick();
    lock = 1;
    wait_state(2, 300, "mid_hold");
    repeat (10) tick();
    rst_n = 0;
    repeat (3) tick();
    check("mid_state", seq_state_o, 0);
    check("mid_periph", periph_rst_o, 1);
    check("mid_erst", soc_erst_n_o, 0);
    check("mid_dwake", dwakeup_n_o, 1);
    check("mid_rcnt", rst_cnt_o, 0);
    rst_n = 1;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
